// File: rtl/fetch_pc_unit_if.sv
// Handshake and decode bus between the fetch/PC stage and its environment
// (top level or testbench on the master side, fetch_pc_unit on the slave side).
interface fetch_pc_unit_if #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
);
  logic             Start;
  logic [PC_W-1:0]  StartAddr;
  logic             BranchEn;
  logic             BOLEn;
  logic             Jump;
  logic             Ack;
  logic             CondFlag;
  logic [PC_W-1:0]  Target;
  logic [PC_W-1:0]  PC;
  logic             FetchValid;
  logic             Done;
  logic [CNT_W-1:0] CycleCnt;

  modport master (
    output Start, StartAddr, BranchEn, BOLEn, Jump, Ack, CondFlag, Target,
    input  PC, FetchValid, Done, CycleCnt
  );

  modport slave (
    input  Start, StartAddr, BranchEn, BOLEn, Jump, Ack, CondFlag, Target,
    output PC, FetchValid, Done, CycleCnt
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch / program-counter stage. Holds the PC addressing the
// instruction ROM, sequences IDLE -> RUN -> DONE around a start/done
// handshake and counts RUN cycles with a saturating counter.
module fetch_pc_unit #(
  parameter int              PC_W     = 10,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic            Clk,
  input  logic            Reset,
  fetch_pc_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [PC_W-1:0]  pc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             fetch_valid_q;
  logic             done_q;

  logic             branch_taken;
  logic [PC_W-1:0]  pc_run_d;
  logic [CNT_W-1:0] cnt_inc_d;

  // Branch fires when the flag matches the inverted polarity bit.
  assign branch_taken = bus.BranchEn && (bus.CondFlag == ~bus.BOLEn);

  // Next PC for a non-halting RUN cycle; wraps modulo 2^PC_W naturally.
  always_comb begin
    pc_run_d = pc_q + PC_W'(1);
    if (branch_taken) begin
      pc_run_d = bus.Target;
    end else if (bus.Jump && bus.CondFlag) begin
      pc_run_d = pc_q + PC_W'(2);
    end
  end

  // Saturating increment of the executed-cycle counter.
  always_comb begin
    cnt_inc_d = cnt_q + CNT_W'(1);
    if (cnt_q == {CNT_W{1'b1}}) begin
      cnt_inc_d = cnt_q;
    end
  end

  // Control FSM with registered PC, counter and status outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      cnt_q         <= '0;
      fetch_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.Start) begin
            state_q       <= S_RUN;
            pc_q          <= bus.StartAddr;
            cnt_q         <= '0;
            fetch_valid_q <= 1'b1;
            done_q        <= 1'b0;
          end
        end
        S_RUN: begin
          // The halt cycle itself is counted before stopping.
          cnt_q <= cnt_inc_d;
          if (bus.Ack) begin
            state_q       <= S_DONE;
            fetch_valid_q <= 1'b0;
            done_q        <= 1'b1;
          end else begin
            pc_q <= pc_run_d;
          end
        end
        default: begin
          state_q       <= S_IDLE;
          fetch_valid_q <= 1'b0;
          done_q        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.PC         = pc_q;
  assign bus.FetchValid = fetch_valid_q;
  assign bus.Done       = done_q;
  assign bus.CycleCnt   = cnt_q;

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch / program-counter stage sitting directly upstream of the control decoder.
- Holds the PC that addresses instruction ROM and sequences program start and finish.
- Each cycle it takes the decoder's BranchEn / BOLEn / Jump / Ack for the instruction at the current PC, plus the ALU condition flag, and computes the next PC.
- Runs a start/done handshake with the testbench or top level, and counts executed cycles.

Parameters:
- PC_W, 10, PC / instruction-ROM address width (ROM depth 2^PC_W).
- RESET_PC, 0, PC value after Reset.
- CNT_W, 16, width of the executed-cycle counter.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  level request to begin a program; sampled only in IDLE or DONE.
- StartAddr  input  PC_W  entry PC loaded when Start is accepted.
- BranchEn  input  1  decoder: current instruction is a branch.
- BOLEn  input  1  decoder: branch polarity; 1 = branch when CondFlag==0, 0 = branch when CondFlag==1.
- Jump  input  1  decoder: conditional-skip instruction; skip next instruction when CondFlag==1.
- Ack  input  1  decoder: current instruction is the halt word.
- CondFlag  input  1  ALU condition flag from the previous set/compare instruction.
- Target  input  PC_W  absolute branch target from the branch LUT.
- PC  output  PC_W  current instruction address.
- FetchValid  output  1  high in RUN only; decoder inputs are meaningful only when high.
- Done  output  1  high in DONE state.
- CycleCnt  output  CNT_W  number of RUN cycles since the last accepted Start.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, PC=RESET_PC, FetchValid=0, Done=0, CycleCnt=0. Reset takes priority over every other event and aborts RUN mid-program with no further PC update.
- FSM states:
  - IDLE: PC held. Start=1 → PC<=StartAddr, CycleCnt<=0, next state RUN.
  - RUN: FetchValid=1. CycleCnt increments every cycle, saturating at all-ones (no wrap). Next PC is chosen by the priority order below.
  - DONE: Done=1, PC and CycleCnt held. Start=1 → PC<=StartAddr, CycleCnt<=0, Done<=0, next state RUN. Start held high in DONE therefore restarts one cycle after entering DONE.
- Next-PC priority in RUN:
  1. Ack=1 → state DONE, PC held at the halt address. The halt cycle is counted.
  2. Branch taken, i.e. BranchEn=1 and CondFlag==~BOLEn → PC<=Target.
  3. Jump=1 and CondFlag=1 → PC<=PC+2.
  4. Otherwise → PC<=PC+1.
- The same priority resolves simultaneous events: Ack beats Branch beats Jump. BranchEn=1 with the condition false falls through to rule 3, then rule 4.
- PC arithmetic is modulo 2^PC_W. PC=2^PC_W-1 with +1 gives 0; with +2 gives 1. Target is used unmodified.
- Start during RUN is ignored. BranchEn/Jump/Ack are ignored in IDLE and DONE.
- Zero-latency decode loop: PC drives ROM combinationally and the decoder outputs return the same cycle. One instruction per cycle, no stalls, no branch delay slot.
- Done is registered: it rises the cycle after Ack is seen in RUN.

Test Plan:
- Reset then Start=1, StartAddr=0x010, all decode inputs 0 for 4 cycles → PC sequence 0x010,0x011,0x012,0x013,0x014; FetchValid=1 from the first RUN cycle; CycleCnt=4.
- In RUN at PC=0x020: BranchEn=1, BOLEn=0, CondFlag=1, Target=0x155 → next PC=0x155. Repeat with CondFlag=0 → next PC=0x021. Repeat with BOLEn=1, CondFlag=0 → next PC=0x155.
- Jump=1: CondFlag=1 at PC=0x030 → next PC 0x032; CondFlag=0 → next PC 0x031. Jump=1 with CondFlag=1 at PC=0x3FF (PC_W=10) → next PC 0x001. Plain +1 at 0x3FF → next PC 0x000.
- Ack=1 together with BranchEn=1 (condition true) at PC=0x040 → next state DONE; PC stays 0x040; Done=1 the following cycle; FetchValid=0. Start=1, StartAddr=0x000 → RUN at PC 0x000; CycleCnt cleared.
- Reset asserted mid-RUN at PC=0x123 → next cycle PC=RESET_PC, IDLE, Done=0, CycleCnt=0. Start=1 pulsed during RUN → no effect on PC.
- CNT_W=4 instance run for 20 cycles without Ack → CycleCnt saturates at 0xF.
